// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and the IF/ID pipeline record
// Contents:
//   PC_W       program counter width in bits
//   NOP_INSTR  encoding of addi x0,x0,0, used for pipeline bubbles
//   if_id_t    IF/ID register record {valid, pc, pc4, instr}, also used by decode
package core_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc4;
    logic [31:0]     instr;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with reset/redirect/stall/increment priority
// Ports:
//   SYS_clk         clock, rising edge
//   SYS_reset       synchronous active-high reset, loads RESET_PC
//   stall           hold the PC
//   redirect_valid  load redirect_pc with low bits cleared (overrides stall)
//   redirect_pc     byte target address
//   pc              current byte PC, low two bits always zero
module pc_reg
  import core_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      // Instructions are word aligned; drop any stray byte offset.
      pc <= redirect_pc & ~32'h3;
    end else if (!stall) begin
      // Natural 32-bit wrap from 0xFFFF_FFFC to 0.
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem addressing and IF/ID register
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds the misaligned output)
// Ports:
//   SYS_clk, SYS_reset      clock and synchronous active-high reset
//   stall                   hold PC and IF/ID
//   redirect_valid/_pc      taken branch/jump; squashes the in-flight fetch
//   imem_addr               word index into instruction memory
//   imem_instr              combinational instruction word for imem_addr
//   if_id_valid/pc/pc4/instr  IF/ID register outputs to decode
//   misaligned              1-cycle pulse after a redirect with nonzero low bits
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  logic [PC_W-1:0] pc;
  if_id_t          if_id;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .SYS_clk       (SYS_clk),
    .SYS_reset     (SYS_reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc)
  );

  assign imem_addr = {2'b00, pc[31:2]};

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      if_id.valid <= 1'b0;
      if_id.pc    <= RESET_PC;
      if_id.pc4   <= RESET_PC + 32'd4;
      if_id.instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      // Wrong-path word is dropped; pc/pc4 are left as they were.
      if_id.valid <= 1'b0;
      if_id.instr <= NOP_INSTR;
    end else if (!stall) begin
      if_id.valid <= 1'b1;
      if_id.pc    <= pc;
      if_id.pc4   <= pc + 32'd4;
      if_id.instr <= imem_instr;
    end
  end

  assign if_id_valid = if_id.valid;
  assign if_id_pc    = if_id.pc;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_instr = if_id.instr;

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end
`endif

endmodule
